// File: rtl/yurut_pkg.sv
`default_nettype none
// yurut_pkg : execute-stage types shared by the MUIB sequencer and its FIFO (rev 1.0)
package yurut_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muib_islem_t;

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    YURUT  = 2'd1,
    SONUC  = 2'd2,
    BOSALT = 2'd3
  } muib_den_durum_t;

  typedef struct packed {
    muib_islem_t islem;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } muib_istek_t;

  localparam int unsigned ISTEK_W = $bits(muib_istek_t);

  // DIV/DIVU/REM/REMU all have the top opcode bit set
  function automatic logic bolme_mu(input muib_islem_t islem);
    return islem[2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/muib_istek_fifo.sv
`default_nettype none
// muib_istek_fifo : registered request FIFO with synchronous flush (rev 1.0)
module muib_istek_fifo #(
  parameter int unsigned DERINLIK = 2,
  parameter int unsigned GENISLIK = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                temizle,
  input  logic                yaz,
  input  logic [GENISLIK-1:0] yaz_veri,
  input  logic                oku,
  output logic [GENISLIK-1:0] bas,
  output logic                bos,
  output logic                dolu
);

  localparam int unsigned AW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;

  logic [GENISLIK-1:0] bellek [DERINLIK];
  logic [AW:0]         yaz_ptr;
  logic [AW:0]         oku_ptr;

  // extra pointer bit tells full from empty when the index bits coincide
  assign bos  = (yaz_ptr == oku_ptr);
  assign dolu = (yaz_ptr[AW] != oku_ptr[AW]) && (yaz_ptr[AW-1:0] == oku_ptr[AW-1:0]);
  assign bas  = bellek[oku_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (yaz && !dolu) begin
      bellek[yaz_ptr[AW-1:0]] <= yaz_veri;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
    end else if (temizle) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
    end else begin
      if (yaz && !dolu) yaz_ptr <= yaz_ptr + 1'b1;
      if (oku && !bos)  oku_ptr <= oku_ptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/muib_denetleyici.sv
`default_nettype none
// muib_denetleyici : queues mul/div requests and sequences them through the MUIB one at a time (rev 1.0)
module muib_denetleyici
  import yurut_pkg::*;
#(
  parameter int unsigned DERINLIK     = 2,
  parameter bit          KISAYOL_ACIK = 1'b1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        istek_gecerli_i,
  output logic        istek_hazir_o,
  input  logic [2:0]  istek_islem_i,
  input  logic [31:0] istek_rs1_i,
  input  logic [31:0] istek_rs2_i,
  input  logic [4:0]  istek_rd_i,
  input  logic        temizle_i,
  output logic        muib_aktif_o,
  output logic [2:0]  muib_islem_o,
  output logic [31:0] muib_rs1_o,
  output logic [31:0] muib_rs2_o,
  input  logic        muib_hazir_i,
  input  logic [31:0] muib_sonuc_i,
  output logic        muib_tuket_o,
  output logic        sonuc_gecerli_o,
  input  logic        sonuc_hazir_i,
  output logic [31:0] sonuc_o,
  output logic [4:0]  sonuc_rd_o,
  output logic        mesgul_o
);

  muib_den_durum_t durum, sonraki;
  muib_istek_t     yeni, bas;
  logic            bos, dolu, yaz, oku;
  logic            kisayol_var;
  logic [31:0]     kisayol_deger;
  logic            kisayol_yukle, yurut_yukle, yakala, tuket;
  muib_islem_t     islem_r;
  logic [31:0]     rs1_r, rs2_r, sonuc_r;
  logic [4:0]      rd_r;

  assign istek_hazir_o = rstn_i && !dolu;
  assign yaz           = istek_gecerli_i && istek_hazir_o && !temizle_i;
  assign yeni          = {istek_islem_i, istek_rs1_i, istek_rs2_i, istek_rd_i};

  muib_istek_fifo #(
    .DERINLIK (DERINLIK),
    .GENISLIK (ISTEK_W)
  ) u_fifo (
    .clk      (clk_i),
    .rstn     (rstn_i),
    .temizle  (temizle_i),
    .yaz      (yaz),
    .yaz_veri (yeni),
    .oku      (oku),
    .bas      (bas),
    .bos      (bos),
    .dolu     (dolu)
  );

  // trivial divisions whose result is fixed by the operands alone
  always_comb begin
    kisayol_var   = 1'b0;
    kisayol_deger = '0;
    if (bas.rs2 == '0) begin
      if (bas.islem inside {DIV, DIVU}) begin
        kisayol_var   = 1'b1;
        kisayol_deger = '1;
      end else if (bas.islem inside {REM, REMU}) begin
        kisayol_var   = 1'b1;
        kisayol_deger = bas.rs1;
      end
    end else if (bas.rs1 == 32'h8000_0000 && bas.rs2 == 32'hFFFF_FFFF) begin
      if (bas.islem == DIV) begin
        kisayol_var   = 1'b1;
        kisayol_deger = 32'h8000_0000;
      end else if (bas.islem == REM) begin
        kisayol_var   = 1'b1;
        kisayol_deger = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) durum <= BOSTA;
    else         durum <= sonraki;
  end

  always_comb begin
    sonraki       = durum;
    oku           = 1'b0;
    kisayol_yukle = 1'b0;
    yurut_yukle   = 1'b0;
    yakala        = 1'b0;
    tuket         = 1'b0;
    case (durum)
      BOSTA: begin
        if (!bos && !temizle_i) begin
          oku = 1'b1;
          if (bas.rd == '0) begin
            sonraki = BOSTA;
          end else if (KISAYOL_ACIK && kisayol_var) begin
            kisayol_yukle = 1'b1;
            sonraki       = SONUC;
          end else begin
            yurut_yukle = 1'b1;
            sonraki     = YURUT;
          end
        end
      end
      YURUT: begin
        if (muib_hazir_i) begin
          tuket = 1'b1;
          if (temizle_i) begin
            sonraki = BOSTA;
          end else begin
            yakala  = 1'b1;
            sonraki = SONUC;
          end
        end else if (temizle_i) begin
          // a started division must run to completion before the unit is reused
          sonraki = bolme_mu(islem_r) ? BOSALT : BOSTA;
        end
      end
      SONUC: begin
        if (temizle_i || sonuc_hazir_i) sonraki = BOSTA;
      end
      BOSALT: begin
        if (muib_hazir_i) begin
          tuket   = 1'b1;
          sonraki = BOSTA;
        end
      end
      default: sonraki = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      islem_r <= MUL;
      rs1_r   <= '0;
      rs2_r   <= '0;
      rd_r    <= '0;
      sonuc_r <= '0;
    end else begin
      if (yurut_yukle) begin
        islem_r <= bas.islem;
        rs1_r   <= bas.rs1;
        rs2_r   <= bas.rs2;
      end
      if (yurut_yukle || kisayol_yukle) rd_r <= bas.rd;
      if (kisayol_yukle)  sonuc_r <= kisayol_deger;
      else if (yakala)    sonuc_r <= muib_sonuc_i;
    end
  end

  assign muib_aktif_o    = (durum == YURUT) || (durum == BOSALT);
  assign muib_islem_o    = islem_r;
  assign muib_rs1_o      = rs1_r;
  assign muib_rs2_o      = rs2_r;
  assign muib_tuket_o    = tuket;
  assign sonuc_gecerli_o = (durum == SONUC);
  assign sonuc_o         = sonuc_r;
  assign sonuc_rd_o      = rd_r;
  assign mesgul_o        = !bos || (durum != BOSTA);

endmodule
`default_nettype wire
